// File: rtl/scanner_pkg.sv
// Shared types and helpers for multi_phase_scanner.
// Contents: scan_state_e (IDLE/ACTIVE/BLANK) and next_enabled(), which finds
// the next enabled phase index in rotation from a mask.
package scanner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } scan_state_e;

  // Widest scanner supported by next_enabled().
  localparam int unsigned MAX_PHASES = 64;
  localparam int unsigned PKG_IDX_W  = 6;

  // Lowest enabled index strictly after cur, searching cur+1 .. cur+n
  // modulo n. The search can land back on cur when it is the only enabled
  // phase. When nothing is enabled, cur is returned unchanged.
  function automatic logic [PKG_IDX_W-1:0] next_enabled(
    input logic [MAX_PHASES-1:0] mask,
    input logic [PKG_IDX_W-1:0]  cur,
    input int unsigned           n
  );
    logic [PKG_IDX_W-1:0] result;
    logic [PKG_IDX_W-1:0] idx;
    logic                 found;
    result = cur;
    found  = 1'b0;
    for (int unsigned k = 1; k <= MAX_PHASES; k++) begin
      if (k <= n) begin
        idx = PKG_IDX_W'((32'(cur) + k) % n);
        if (!found && mask[idx]) begin
          result = idx;
          found  = 1'b1;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter used to time the dwell and blank intervals.
// Ports:
//   clk, reset   - clock and asynchronous active-low reset
//   load         - load load_val on the next edge
//   load_val     - count to load; the interval lasts load_val+1 cycles
//   tc           - registered flag, high while the count is zero
// The counter saturates at zero and never wraps.
module phase_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;

  // Next count: load takes priority, otherwise count down to zero and hold.
  always_comb begin
    count_d = count;
    if (load) begin
      count_d = load_val;
    end else if (count != '0) begin
      count_d = count - CNT_W'(1);
    end
  end

  // tc is registered from the next count so that it matches count == 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tc    <= 1'b1;
    end else begin
      count <= count_d;
      tc    <= (count_d == '0);
    end
  end

endmodule

// File: rtl/multi_phase_scanner.sv
// One-hot multi-phase scanner for display digit-select and keypad row scanning.
// Each phase stays active for DWELL_CYCLES clocks. It is followed by
// BLANK_CYCLES clocks of all-zero output, and then the scanner moves on to the
// next phase.
// Optional feature macro: PHASE_MASK_EN adds phase_mask, which selects the
// phases that take part in the scan.
// Ports:
//   clk, reset   - clock and asynchronous active-low reset
//   en           - run enable; low returns to idle at the next edge
//   phase_mask   - (PHASE_MASK_EN only) enabled phases, sampled at advances
//   one_hot_out  - one-hot phase select, zero while idle or blanking
//   phase_idx    - current phase, or the phase that just finished while blanking
//   phase_start  - pulse on the first active cycle of each phase
//   frame_done   - pulse with phase_start when the phase index wraps
//   blanking     - high during the blank gap
module multi_phase_scanner
  import scanner_pkg::*;
#(
  parameter int unsigned NUM_PHASES   = 4,
  parameter int unsigned DWELL_CYCLES = 3,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
`ifdef PHASE_MASK_EN
  input  logic [NUM_PHASES-1:0]         phase_mask,
`endif
  output logic [NUM_PHASES-1:0]         one_hot_out,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic                          phase_start,
  output logic                          frame_done,
  output logic                          blanking
);

  localparam int unsigned IDX_W   = $clog2(NUM_PHASES);
  localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  scan_state_e             state_q;
  scan_state_e             state_d;
  logic [IDX_W-1:0]        phase_d;
  logic [IDX_W-1:0]        next_idx;
  logic [IDX_W-1:0]        first_idx;
  logic [NUM_PHASES-1:0]   mask_c;
  logic [MAX_PHASES-1:0]   mask_ext;
  logic                    mask_any;
  logic                    advance;
  logic                    load;
  logic [CNT_W-1:0]        load_val;
  logic                    tc;
  logic [NUM_PHASES-1:0]   one_hot_d;
  logic                    start_d;
  logic                    frame_d;
  logic                    blank_d;

`ifdef PHASE_MASK_EN
  assign mask_c = phase_mask;
`else
  assign mask_c = '1;
`endif

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .tc      (tc)
  );

  // Next-state logic and next values for the registered outputs.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_idx;
    load     = 1'b0;
    load_val = '0;
    start_d  = 1'b0;
    frame_d  = 1'b0;
    advance  = 1'b0;
    mask_ext = '0;
    mask_ext[NUM_PHASES-1:0] = mask_c;
    mask_any  = |mask_c;
    next_idx  = IDX_W'(next_enabled(mask_ext, PKG_IDX_W'(phase_idx), NUM_PHASES));
    // The search starts after the top index, so it returns the lowest enabled phase.
    first_idx = IDX_W'(next_enabled(mask_ext, PKG_IDX_W'(NUM_PHASES - 1), NUM_PHASES));

    case (state_q)
      IDLE: begin
        if (mask_any) begin
          state_d  = ACTIVE;
          phase_d  = first_idx;
          load     = 1'b1;
          load_val = DWELL_LOAD;
          start_d  = 1'b1;
        end
      end
      ACTIVE: begin
        if (tc) begin
          if (BLANK_CYCLES > 0) begin
            state_d  = BLANK;
            load     = 1'b1;
            load_val = BLANK_LOAD;
          end else begin
            advance = 1'b1;
          end
        end
      end
      BLANK: begin
        if (tc) begin
          advance = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    // The mask is read only here, so an active phase always runs to completion.
    if (advance) begin
      load = 1'b1;
      if (!mask_any) begin
        state_d = IDLE;
        phase_d = '0;
      end else begin
        state_d  = ACTIVE;
        phase_d  = next_idx;
        load_val = DWELL_LOAD;
        start_d  = 1'b1;
        frame_d  = (next_idx <= phase_idx);
      end
    end

    // Dropping en overrides everything; the next start is from the first phase.
    if (!en) begin
      state_d  = IDLE;
      phase_d  = '0;
      load     = 1'b1;
      load_val = '0;
      start_d  = 1'b0;
      frame_d  = 1'b0;
    end

    one_hot_d = (state_d == ACTIVE) ? (NUM_PHASES'(1) << phase_d) : '0;
    blank_d   = (state_d == BLANK);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      phase_idx   <= '0;
      one_hot_out <= '0;
      phase_start <= 1'b0;
      frame_done  <= 1'b0;
      blanking    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_idx   <= phase_d;
      one_hot_out <= one_hot_d;
      phase_start <= start_d;
      frame_done  <= frame_d;
      blanking    <= blank_d;
    end
  end

endmodule
